fp_norm_round: RTL and testbench
================================

FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  raw product from multiplier valid.
REQ-004 in_ready  output  1  block can accept the raw product this cycle.
REQ-005 in_sign  input  1  product sign (s1 XOR s2).
REQ-006 in_exp  input  10  two's-complement biased exponent, e1+e2-127.
REQ-007 in_mant  input  48  unsigned 24x24 significand product, hidden bits included.
REQ-008 in_special  input  2  00 normal, 01 zero, 10 infinity, 11 NaN/invalid.
REQ-009 in_opcode  input  6  operation tag, carried unchanged to out_opcode.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out_result  output  32  IEEE-754 single-precision result.
REQ-013 out_flags  output  4  {invalid, overflow, underflow, inexact}.
REQ-014 out_opcode  output  6  tag of the result on out_result.

Function
REQ-015 The block SHALL be a 2-stage valid/ready pipeline, S1 normalize and S2 round/pack, with latency 2 cycles from accept to out_valid when not stalled.
REQ-016 A transfer SHALL occur on a port only when valid and ready are both high in the same cycle.
REQ-017 S2 SHALL advance when it is empty or when out_ready is high; S1 SHALL advance when S2 advances or S1 is empty; in_ready SHALL equal the S1 advance condition.
REQ-018 While out_valid=1 and out_ready=0, out_result, out_flags and out_opcode SHALL hold stable.
REQ-019 Simultaneous accept and drain SHALL sustain 1 result per cycle with no bubble.
REQ-020 S1 normalize: if in_mant[47]=1, fraction=in_mant[46:24], guard=[23], sticky=OR[22:0], exp+1; otherwise fraction=[45:23], guard=[22], sticky=OR[21:0], exp unchanged.
REQ-021 S2 rounding SHALL be round-to-nearest-even: increment when guard AND (sticky OR fraction LSB).
REQ-022 A fraction carry-out on increment SHALL zero the fraction and increment the exponent.
REQ-023 A final exponent >=255 SHALL produce signed infinity with overflow=1 and inexact=1.
REQ-024 A final exponent <=0 SHALL flush to signed zero (no subnormals) with underflow=1 and inexact=1.
REQ-025 inexact SHALL be set whenever guard OR sticky is 1.
REQ-026 For in_special=01, the block SHALL output signed zero; for 10, signed infinity; for 11, 32'h7FC00000 with invalid=1. Other flags SHALL be 0 in all three cases, and the mantissa path SHALL be ignored.
REQ-027 in_mant=0 with in_special=00 SHALL be treated as zero.

Reset
REQ-028 Asserting rst_n low SHALL clear both stage-valid bits immediately, including mid-operation, discarding any in-flight results.
REQ-029 During and after reset: out_valid=0, out_result=0, out_flags=0, out_opcode=0, and in_ready=1 from the first cycle after release.

Structure
REQ-030 Package fp_pkg SHALL hold the following: BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, the special-code constants, and the flag bit indices.
REQ-031 Rounding logic (fraction, guard, sticky, exponent to packed word and flags) SHALL be one combinational sub-module, fp_round_rne.

Verification
REQ-032 Input in_exp=127, in_mant=48'h9000_0000_0000, sign=0 -> out_result=32'h40100000 and flags=0, exactly 2 cycles later.
REQ-033 Input in_exp=372, in_mant=48'h7000_0000_0000, sign=0 (0xFD000000*0xFCE00000) -> 32'h7F800000 with overflow=1 and inexact=1.
REQ-034 Tie cases at in_exp=127:
- in_mant=48'h4000_0040_0000 -> 32'h3F800000, inexact=1.
- in_mant=48'h4000_00C0_0000 -> 32'h3F800002, inexact=1.
REQ-035 Special and underflow cases:
- in_special=11 -> 32'h7FC00000, invalid=1.
- in_special=01 with sign=1 -> 32'h80000000.
- in_exp=-5 -> signed zero with underflow=1.
REQ-036 Backpressure: with out_ready=0, offer 3 back-to-back inputs -> in_ready drops after 2 accepts and out_result holds. Then raise out_ready -> all 3 results emerge in order, 1 per cycle, with tags matching.
REQ-037 Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0 immediately. After release, no stale result is emitted.

Source files
------------

// File: rtl/fp_norm_round_pkg.sv
// Shared constants and types for the FP multiply normalize/round pipeline.
// Pure declarations, no logic or latency.
// No flow-control behaviour lives here.
package fp_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;   // 255: all-ones exponent field
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Special-case code attached to each raw product
    typedef enum logic [1:0] {
        SPC_NORMAL = 2'b00,
        SPC_ZERO   = 2'b01,
        SPC_INF    = 2'b10,
        SPC_NAN    = 2'b11
    } special_e;

    // Bit positions inside the 4-bit flag word {invalid, overflow, underflow, inexact}
    localparam int FLG_INEXACT   = 0;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_INVALID   = 3;

    // Normalized operand held in the first pipeline stage
    typedef struct packed {
        logic        sign;
        logic [10:0] exp;      // two's complement, widened so +1 cannot wrap
        logic [22:0] frac;
        logic        guard;
        logic        sticky;
        special_e    special;
        logic [5:0]  opcode;
    } s1_t;

endpackage

// File: rtl/fp_norm_round_if.sv
// Handshake bundle between the multiplier, the normalize/round block and its consumer.
// No latency; wires only.
// master drives in_* data/valid and out_ready; slave is the rounding pipeline.
interface fp_norm_round_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic [1:0]  in_special;
    logic [5:0]  in_opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [5:0]  out_opcode;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_special, in_opcode, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_opcode
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_special, in_opcode, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_opcode
    );
endinterface

// File: rtl/fp_norm_round_rne.sv
// Round-to-nearest-even and pack into IEEE-754 single, with overflow/flush-to-zero.
// Purely combinational, zero latency.
// No handshake; the enclosing pipeline owns flow control.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic        sign,
    input  logic [10:0] exp,
    input  logic [22:0] frac,
    input  logic        guard,
    input  logic        sticky,
    input  special_e    special,
    output logic [31:0] result,
    output logic [3:0]  flags
);
    logic        round_up;
    logic [23:0] frac_inc;
    logic [11:0] exp_fin;

    assign round_up = guard & (sticky | frac[0]);
    assign frac_inc = {1'b0, frac} + {23'd0, round_up};
    // A carry out of the fraction leaves it zero and bumps the exponent
    assign exp_fin  = {exp[10], exp} + {11'd0, frac_inc[23]};

    // Select special encodings or the rounded normal result, with range clamping
    always_comb begin
        result = '0;
        flags  = '0;
        case (special)
            SPC_ZERO: result = {sign, 31'd0};
            SPC_INF:  result = {sign, 8'hFF, 23'd0};
            SPC_NAN: begin
                result              = QNAN;
                flags[FLG_INVALID]  = 1'b1;
            end
            default: begin
                flags[FLG_INEXACT] = guard | sticky;
                if ($signed(exp_fin) >= EXP_MAX) begin
                    result               = {sign, 8'hFF, 23'd0};
                    flags[FLG_OVERFLOW]  = 1'b1;
                    flags[FLG_INEXACT]   = 1'b1;
                end else if ($signed(exp_fin) <= 0) begin
                    // No subnormal support: anything below the normal range flushes
                    result               = {sign, 31'd0};
                    flags[FLG_UNDERFLOW] = 1'b1;
                    flags[FLG_INEXACT]   = 1'b1;
                end else begin
                    result = {sign, exp_fin[7:0], frac_inc[22:0]};
                end
            end
        endcase
    end
endmodule

// File: rtl/fp_norm_round.sv
// Normalizes a raw 24x24 significand product, rounds RNE and packs IEEE-754 single.
// Latency 2 cycles (S1 normalize, S2 round/pack), 1 result/cycle sustained.
// Valid/ready: each stage advances when downstream advances or the stage is empty.
module fp_norm_round
    import fp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    fp_norm_round_if.slave bus
);
    logic        s1_vld_q, s1_vld_d;
    s1_t         s1_q, s1_d;
    logic        s2_vld_q, s2_vld_d;
    logic [31:0] s2_result_q, s2_result_d;
    logic [3:0]  s2_flags_q, s2_flags_d;
    logic [5:0]  s2_opcode_q, s2_opcode_d;

    logic        s1_adv, s2_adv;
    logic [10:0] exp_ext;
    logic [31:0] rnd_result;
    logic [3:0]  rnd_flags;

    assign s2_adv  = !s2_vld_q || bus.out_ready;
    assign s1_adv  = s2_adv || !s1_vld_q;
    assign exp_ext = {bus.in_exp[9], bus.in_exp};

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = s2_vld_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_flags  = s2_flags_q;
    assign bus.out_opcode = s2_opcode_q;

    // S1: align the product so the hidden bit is dropped and extract guard/sticky
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        if (s1_adv) begin
            s1_vld_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.sign   = bus.in_sign;
                s1_d.opcode = bus.in_opcode;
                if (bus.in_mant[47]) begin
                    s1_d.frac   = bus.in_mant[46:24];
                    s1_d.guard  = bus.in_mant[23];
                    s1_d.sticky = |bus.in_mant[22:0];
                    s1_d.exp    = exp_ext + 11'd1;
                end else begin
                    s1_d.frac   = bus.in_mant[45:23];
                    s1_d.guard  = bus.in_mant[22];
                    s1_d.sticky = |bus.in_mant[21:0];
                    s1_d.exp    = exp_ext;
                end
                // A zero product with a "normal" tag is routed through the zero path
                if (bus.in_special == SPC_NORMAL && bus.in_mant == 48'd0)
                    s1_d.special = SPC_ZERO;
                else
                    s1_d.special = special_e'(bus.in_special);
            end
        end
    end

    fp_round_rne u_round (
        .sign    (s1_q.sign),
        .exp     (s1_q.exp),
        .frac    (s1_q.frac),
        .guard   (s1_q.guard),
        .sticky  (s1_q.sticky),
        .special (s1_q.special),
        .result  (rnd_result),
        .flags   (rnd_flags)
    );

    // S2: capture the packed result; holds steady while the consumer stalls
    always_comb begin
        s2_vld_d    = s2_vld_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        s2_opcode_d = s2_opcode_q;
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_result_d = rnd_result;
                s2_flags_d  = rnd_flags;
                s2_opcode_d = s1_q.opcode;
            end
        end
    end

    // Pipeline registers; reset drops any in-flight work immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_q        <= '0;
            s2_vld_q    <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            s2_opcode_q <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_q        <= s1_d;
            s2_vld_q    <= s2_vld_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            s2_opcode_q <= s2_opcode_d;
        end
    end
endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: rounding vectors, specials, backpressure, reset.
// Expected values are hand-derived constants.
// Drives inputs #1 after the rising edge and samples at the same point.
module tb_fp_norm_round;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    fp_norm_round_if bus ();

    fp_norm_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
    endtask

    task automatic drive(input logic sg, input logic [9:0] e, input logic [47:0] m,
                         input logic [1:0] sp, input logic [5:0] op);
        bus.in_valid   = 1'b1;
        bus.in_sign    = sg;
        bus.in_exp     = e;
        bus.in_mant    = m;
        bus.in_special = sp;
        bus.in_opcode  = op;
    endtask

    // One transaction with a free-running consumer; checks 2-cycle latency and the result
    task automatic run_vec(input string tag, input logic sg, input logic [9:0] e,
                           input logic [47:0] m, input logic [1:0] sp, input logic [5:0] op,
                           input logic [31:0] er, input logic [3:0] ef);
        bus.out_ready = 1'b1;
        drive(sg, e, m, sp, op);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, "_early"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_valid"},  64'(bus.out_valid),  64'd1);
        check({tag, "_result"}, 64'(bus.out_result), 64'(er));
        check({tag, "_flags"},  64'(bus.out_flags),  64'(ef));
        check({tag, "_opcode"}, 64'(bus.out_opcode), 64'(op));
    endtask

    initial begin
        logic stale;
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sign = 1'b0;
        bus.in_exp = '0;
        bus.in_mant = '0;
        bus.in_special = '0;
        bus.in_opcode = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        check("rst_out_flags",  64'(bus.out_flags),  64'd0);
        check("rst_out_opcode", 64'(bus.out_opcode), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Main function
        run_vec("basic",     1'b0, 10'd127,  48'h9000_0000_0000, 2'b00, 6'd1,  32'h4010_0000, 4'b0000);
        run_vec("ovf",       1'b0, 10'd372,  48'h7000_0000_0000, 2'b00, 6'd2,  32'h7F80_0000, 4'b0101);
        run_vec("tie_even",  1'b0, 10'd127,  48'h4000_0040_0000, 2'b00, 6'd3,  32'h3F80_0000, 4'b0001);
        run_vec("tie_odd",   1'b0, 10'd127,  48'h4000_00C0_0000, 2'b00, 6'd4,  32'h3F80_0002, 4'b0001);
        run_vec("nan",       1'b0, 10'd127,  48'h4000_0000_0000, 2'b11, 6'd5,  32'h7FC0_0000, 4'b1000);
        run_vec("neg_zero",  1'b1, 10'd127,  48'h9000_0000_0000, 2'b01, 6'd6,  32'h8000_0000, 4'b0000);
        run_vec("neg_inf",   1'b1, 10'd10,   48'h4000_0000_0000, 2'b10, 6'd7,  32'hFF80_0000, 4'b0000);
        run_vec("unf",       1'b0, 10'h3FB,  48'h4000_0000_0000, 2'b00, 6'd8,  32'h0000_0000, 4'b0011);
        run_vec("mant_zero", 1'b1, 10'd127,  48'h0000_0000_0000, 2'b00, 6'd9,  32'h8000_0000, 4'b0000);
        run_vec("carry",     1'b0, 10'd127,  48'h7FFF_FFC0_0000, 2'b00, 6'd10, 32'h4000_0000, 4'b0001);
        run_vec("carry_ovf", 1'b1, 10'd254,  48'h7FFF_FFC0_0000, 2'b00, 6'd11, 32'hFF80_0000, 4'b0101);
        run_vec("min_norm",  1'b0, 10'd1,    48'h4000_0000_0000, 2'b00, 6'd12, 32'h0080_0000, 4'b0000);
        run_vec("max_norm",  1'b0, 10'd254,  48'h4000_0000_0000, 2'b00, 6'd13, 32'h7F00_0000, 4'b0000);
        @(posedge clk); #1;

        // Backpressure: three back-to-back offers into a stalled consumer
        bus.out_ready = 1'b0;
        drive(1'b0, 10'd127, 48'h9000_0000_0000, 2'b00, 6'd21);
        check("bp_rdy_a", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        drive(1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00, 6'd22);
        check("bp_rdy_b", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        drive(1'b0, 10'd0, 48'h0, 2'b11, 6'd23);
        check("bp_rdy_c", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        check("bp_stall_rdy", 64'(bus.in_ready),   64'd0);
        check("bp_hold_res1", 64'(bus.out_result), 64'h4010_0000);
        @(posedge clk); #1;
        check("bp_hold_res2", 64'(bus.out_result), 64'h4010_0000);
        check("bp_hold_op",   64'(bus.out_opcode), 64'd21);
        check("bp_hold_flg",  64'(bus.out_flags),  64'd0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_rdy_release", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_b_valid",  64'(bus.out_valid),  64'd1);
        check("bp_b_result", 64'(bus.out_result), 64'h3F80_0002);
        check("bp_b_op",     64'(bus.out_opcode), 64'd22);
        @(posedge clk); #1;
        check("bp_c_valid",  64'(bus.out_valid),  64'd1);
        check("bp_c_result", 64'(bus.out_result), 64'h7FC0_0000);
        check("bp_c_op",     64'(bus.out_opcode), 64'd23);
        @(posedge clk); #1;
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // Reset mid-stream with both stages occupied
        bus.out_ready = 1'b0;
        drive(1'b0, 10'd127, 48'h9000_0000_0000, 2'b00, 6'd31);
        @(posedge clk); #1;
        drive(1'b1, 10'd127, 48'h9000_0000_0000, 2'b00, 6'd32);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("mid_full_valid", 64'(bus.out_valid), 64'd1);
        check("mid_full_rdy",   64'(bus.in_ready),  64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  64'(bus.out_valid),  64'd0);
        check("mid_rst_result", 64'(bus.out_result), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_rdy", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            stale = stale | bus.out_valid;
        end
        check("mid_no_stale", 64'(stale), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
